// File: rtl/sf_rmw.sv
`default_nettype none
// ============================================================================
// Module      : sf_rmw
// Description : Sub-word store unit. A word store is written straight to
//               memory. A half or byte store reads the containing word, merges
//               the new lane(s) and writes the word back. Misaligned and
//               reserved-type requests are rejected without any memory access.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   reset      in   1   synchronous active-high reset
//   start      in   1   store request, sampled only while ready=1
//   s_type     in   2   00 word, 01 half, 10 byte, 11 reserved
//   addr       in  32   byte address of the store
//   wdata      in  32   store data (low half/byte used for sub-word stores)
//   ready      out  1   high in IDLE only
//   done       out  1   one-cycle completion pulse
//   misalign   out  1   qualifies done: request was rejected
//   mem_addr   out 32   word address {addr_q[31:2],2'b00}
//   mem_re     out  1   word read strobe, data valid the following cycle
//   mem_rdata  in  32   word read data
//   mem_we     out  1   word write strobe, commits at the end of the cycle
//   mem_wdata  out 32   merged word to write
//
// Revision    : 1.0 - initial release
// ============================================================================
module sf_rmw (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  s_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  localparam logic [1:0] C_ST_WORD = 2'b00;
  localparam logic [1:0] C_ST_HALF = 2'b01;
  localparam logic [1:0] C_ST_BYTE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      r_state;

  // Request captured at acceptance, plus the word read back from memory.
  logic [1:0]  r_stype_q;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [31:0] r_rd_q;

  logic        r_ready;
  logic        r_done;
  logic        r_misalign;
  logic        r_mem_re;
  logic        r_mem_we;

  logic        w_misaligned;
  logic [31:0] w_merged;

  // Alignment is judged on the live inputs because it decides the very first
  // transition out of IDLE.
  always_comb begin
    w_misaligned = 1'b0;
    case (s_type)
      C_ST_WORD: w_misaligned = (addr[1:0] != 2'b00);
      C_ST_HALF: w_misaligned = addr[0];
      C_ST_BYTE: w_misaligned = 1'b0;
      default:   w_misaligned = 1'b1;
    endcase
  end

  // Write data is a pure function of the captured request and the read-back
  // word, all of them registers, so it is stable for the whole WRITE cycle.
  always_comb begin
    w_merged = r_rd_q;
    case (r_stype_q)
      C_ST_WORD: w_merged = r_wdata_q;
      C_ST_HALF: begin
        if (r_addr_q[1]) begin
          w_merged[31:16] = r_wdata_q[15:0];
        end else begin
          w_merged[15:0]  = r_wdata_q[15:0];
        end
      end
      default: begin
        case (r_addr_q[1:0])
          2'b00:   w_merged[7:0]   = r_wdata_q[7:0];
          2'b01:   w_merged[15:8]  = r_wdata_q[7:0];
          2'b10:   w_merged[23:16] = r_wdata_q[7:0];
          default: w_merged[31:24] = r_wdata_q[7:0];
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_stype_q  <= 2'b00;
      r_addr_q   <= 32'h0;
      r_wdata_q  <= 32'h0;
      r_rd_q     <= 32'h0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_stype_q <= s_type;
            r_addr_q  <= addr;
            r_wdata_q <= wdata;
            r_ready   <= 1'b0;
            if (w_misaligned) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else if (s_type == C_ST_WORD) begin
              r_state  <= S_WRITE;
              r_mem_we <= 1'b1;
            end else begin
              r_state  <= S_READ;
              r_mem_re <= 1'b1;
            end
          end
        end

        // Read data appears one cycle after the strobe, i.e. during CAPTURE.
        S_READ: begin
          r_state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          r_rd_q   <= mem_rdata;
          r_mem_we <= 1'b1;
          r_state  <= S_WRITE;
        end

        S_WRITE: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign misalign  = r_misalign;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;
  assign mem_addr  = {r_addr_q[31:2], 2'b00};
  assign mem_wdata = w_merged;

endmodule
`default_nettype wire
